// File: rtl/bank_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bank_cmd_sequencer
//  Description : Turns one arbitrated DRAM request at a time into legal
//                PRE/ACT/RD/WR commands under an open-page policy. Tracks the
//                open row of all 16 banks and enforces tRP/tRCD/tRAS/tCCD and
//                read/write turnaround timing. Per-bank open status is fed
//                back to the arbiter for row-hit prioritisation.
//  Ports       : clk, rst_n            - clock, asynchronous active-low reset
//                req_*                 - request from arbiter (valid/ready)
//                cmd_valid, cmd, cmd_* - issued command (Mealy, one cycle)
//                bank_open             - bit {bg,ba} set while bank has a row
//                                        open
//  Revision    : 1.0 - initial release
// ============================================================================
module bank_cmd_sequencer #(
    parameter int RA     = 16,
    parameter int CA     = 10,
    parameter int DQ     = 16,
    parameter int IDX    = 6,
    parameter int T_RCD  = 4,
    parameter int T_RP   = 4,
    parameter int T_RAS  = 8,
    parameter int T_CCD  = 2,
    parameter int T_TURN = 3,
    parameter int TW     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [RA-1:0]  req_row,
    input  logic [CA-1:0]  req_col,
    input  logic [1:0]     req_ba,
    input  logic [1:0]     req_bg,
    input  logic           req_t,
    input  logic [DQ-1:0]  req_data,
    input  logic [IDX-1:0] req_idx,
    output logic           cmd_valid,
    output logic [2:0]     cmd,
    output logic [1:0]     cmd_ba,
    output logic [1:0]     cmd_bg,
    output logic [RA-1:0]  cmd_row,
    output logic [CA-1:0]  cmd_col,
    output logic [DQ-1:0]  cmd_data,
    output logic [IDX-1:0] cmd_idx,
    output logic [15:0]    bank_open
);

    localparam logic [2:0] c_CMD_NOP = 3'b000;
    localparam logic [2:0] c_CMD_ACT = 3'b001;
    localparam logic [2:0] c_CMD_PRE = 3'b010;
    localparam logic [2:0] c_CMD_RD  = 3'b011;
    localparam logic [2:0] c_CMD_WR  = 3'b100;

    // A command issued in cycle c loads N-1 so the timer reads 0 at c+N.
    localparam logic [TW-1:0] c_LD_RCD  = TW'(T_RCD - 1);
    localparam logic [TW-1:0] c_LD_RP   = TW'(T_RP - 1);
    localparam logic [TW-1:0] c_LD_RAS  = TW'(T_RAS - 1);
    localparam logic [TW-1:0] c_LD_CCD  = TW'(T_CCD - 1);
    localparam logic [TW-1:0] c_LD_TURN = TW'(T_TURN - 1);
    localparam logic [TW-1:0] c_ONE     = TW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECIDE = 3'd1,
        ST_PRE    = 3'd2,
        ST_ACT    = 3'd3,
        ST_CAS    = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Held request
    logic [RA-1:0]  hold_row_q;
    logic [CA-1:0]  hold_col_q;
    logic [3:0]     hold_bank_q;      // {bg,ba}
    logic           hold_t_q;
    logic [DQ-1:0]  hold_data_q;
    logic [IDX-1:0] hold_idx_q;

    // Bank state and timers
    logic [15:0]    bank_open_q, bank_open_d;
    logic [RA-1:0]  open_row_q  [16];
    logic [RA-1:0]  open_row_d  [16];
    logic [TW-1:0]  wait_tmr_q  [16];
    logic [TW-1:0]  wait_tmr_d  [16];
    logic [TW-1:0]  ras_tmr_q   [16];
    logic [TW-1:0]  ras_tmr_d   [16];
    logic [TW-1:0]  ccd_tmr_q, ccd_tmr_d;
    logic [TW-1:0]  turn_tmr_q, turn_tmr_d;
    logic           last_t_q, last_t_d;

    logic           w_accept;
    logic           w_hit;
    logic           w_cas_ok;
    logic           w_issue_pre;
    logic           w_issue_act;
    logic           w_issue_cas;

    assign req_ready = (state_q == ST_IDLE);
    assign bank_open = bank_open_q;
    assign w_accept  = (state_q == ST_IDLE) && req_valid;
    assign w_hit     = (open_row_q[hold_bank_q] == hold_row_q);

    // Turnaround only matters when the CAS direction flips.
    assign w_cas_ok  = (wait_tmr_q[hold_bank_q] == '0) && (ccd_tmr_q == '0) &&
                       ((hold_t_q == last_t_q) || (turn_tmr_q == '0));

    // ------------------------------------------------------------------
    // FSM next state and Mealy command outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cmd_valid   = 1'b0;
        cmd         = c_CMD_NOP;
        cmd_ba      = '0;
        cmd_bg      = '0;
        cmd_row     = '0;
        cmd_col     = '0;
        cmd_data    = '0;
        cmd_idx     = '0;
        w_issue_pre = 1'b0;
        w_issue_act = 1'b0;
        w_issue_cas = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                if (!bank_open_q[hold_bank_q]) begin
                    state_d = ST_ACT;
                end else if (w_hit) begin
                    state_d = ST_CAS;
                end else begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                if (ras_tmr_q[hold_bank_q] == '0) begin
                    cmd_valid   = 1'b1;
                    cmd         = c_CMD_PRE;
                    cmd_bg      = hold_bank_q[3:2];
                    cmd_ba      = hold_bank_q[1:0];
                    w_issue_pre = 1'b1;
                    state_d     = ST_ACT;
                end
            end
            ST_ACT: begin
                if (wait_tmr_q[hold_bank_q] == '0) begin
                    cmd_valid   = 1'b1;
                    cmd         = c_CMD_ACT;
                    cmd_bg      = hold_bank_q[3:2];
                    cmd_ba      = hold_bank_q[1:0];
                    cmd_row     = hold_row_q;
                    w_issue_act = 1'b1;
                    state_d     = ST_CAS;
                end
            end
            ST_CAS: begin
                if (w_cas_ok) begin
                    cmd_valid   = 1'b1;
                    cmd         = hold_t_q ? c_CMD_WR : c_CMD_RD;
                    cmd_bg      = hold_bank_q[3:2];
                    cmd_ba      = hold_bank_q[1:0];
                    cmd_col     = hold_col_q;
                    cmd_data    = hold_t_q ? hold_data_q : '0;
                    cmd_idx     = hold_idx_q;
                    w_issue_cas = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bank bookkeeping and timers. Every timer counts down every cycle,
    // independent of which bank the FSM is serving; a load overrides.
    // ------------------------------------------------------------------
    always_comb begin
        bank_open_d = bank_open_q;
        last_t_d    = last_t_q;
        ccd_tmr_d   = (ccd_tmr_q  != '0) ? ccd_tmr_q  - c_ONE : '0;
        turn_tmr_d  = (turn_tmr_q != '0) ? turn_tmr_q - c_ONE : '0;
        for (int i = 0; i < 16; i++) begin
            open_row_d[i] = open_row_q[i];
            wait_tmr_d[i] = (wait_tmr_q[i] != '0) ? wait_tmr_q[i] - c_ONE : '0;
            ras_tmr_d[i]  = (ras_tmr_q[i]  != '0) ? ras_tmr_q[i]  - c_ONE : '0;
        end

        if (w_issue_pre) begin
            bank_open_d[hold_bank_q] = 1'b0;
            wait_tmr_d[hold_bank_q]  = c_LD_RP;
        end
        if (w_issue_act) begin
            bank_open_d[hold_bank_q] = 1'b1;
            open_row_d[hold_bank_q]  = hold_row_q;
            wait_tmr_d[hold_bank_q]  = c_LD_RCD;
            ras_tmr_d[hold_bank_q]   = c_LD_RAS;
        end
        if (w_issue_cas) begin
            ccd_tmr_d  = c_LD_CCD;
            turn_tmr_d = c_LD_TURN;
            last_t_d   = hold_t_q;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_row_q  <= '0;
            hold_col_q  <= '0;
            hold_bank_q <= '0;
            hold_t_q    <= 1'b0;
            hold_data_q <= '0;
            hold_idx_q  <= '0;
            bank_open_q <= '0;
            ccd_tmr_q   <= '0;
            turn_tmr_q  <= '0;
            last_t_q    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                open_row_q[i] <= '0;
                wait_tmr_q[i] <= '0;
                ras_tmr_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            bank_open_q <= bank_open_d;
            ccd_tmr_q   <= ccd_tmr_d;
            turn_tmr_q  <= turn_tmr_d;
            last_t_q    <= last_t_d;
            for (int i = 0; i < 16; i++) begin
                open_row_q[i] <= open_row_d[i];
                wait_tmr_q[i] <= wait_tmr_d[i];
                ras_tmr_q[i]  <= ras_tmr_d[i];
            end
            if (w_accept) begin
                hold_row_q  <= req_row;
                hold_col_q  <= req_col;
                hold_bank_q <= {req_bg, req_ba};
                hold_t_q    <= req_t;
                hold_data_q <= req_data;
                hold_idx_q  <= req_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bank_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bank_cmd_sequencer
//  Description : Self-checking bench for bank_cmd_sequencer. A reference model
//                records the cycle of the last PRE/ACT per bank and the last
//                CAS, and predicts the exact issue cycle of every command from
//                the timing rules directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bank_cmd_sequencer;

    localparam int RA = 16, CA = 10, DQ = 16, IDX = 6;
    localparam int T_RCD = 4, T_RP = 4, T_RAS = 8, T_CCD = 2, T_TURN = 3;
    localparam int NEVER = -1000;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [RA-1:0]  req_row;
    logic [CA-1:0]  req_col;
    logic [1:0]     req_ba, req_bg;
    logic           req_t;
    logic [DQ-1:0]  req_data;
    logic [IDX-1:0] req_idx;
    logic           cmd_valid;
    logic [2:0]     cmd;
    logic [1:0]     cmd_ba, cmd_bg;
    logic [RA-1:0]  cmd_row;
    logic [CA-1:0]  cmd_col;
    logic [DQ-1:0]  cmd_data;
    logic [IDX-1:0] cmd_idx;
    logic [15:0]    bank_open;

    always #5 clk = ~clk;

    bank_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_row(req_row), .req_col(req_col), .req_ba(req_ba), .req_bg(req_bg),
        .req_t(req_t), .req_data(req_data), .req_idx(req_idx),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ba(cmd_ba), .cmd_bg(cmd_bg),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data),
        .cmd_idx(cmd_idx), .bank_open(bank_open)
    );

    int cyc;
    int n_checks;
    int n_fail;

    // Reference model: cycle of most recent event, open rows, last CAS type.
    int          last_pre [16];
    int          last_act [16];
    int          last_cas;
    bit          m_open   [16];
    logic [15:0] m_row    [16];
    bit          m_last_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            last_pre[i] = NEVER;
            last_act[i] = NEVER;
            m_open[i]   = 1'b0;
            m_row[i]    = '0;
        end
        last_cas = NEVER;
        m_last_t = 1'b0;
    endtask

    function automatic logic [15:0] open_mask();
        logic [15:0] m;
        for (int i = 0; i < 16; i++) m[i] = m_open[i];
        return m;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_quiet(input string tag, input logic exp_ready);
        chk({tag, "_cmd"}, {61'd0, cmd_valid, 2'b00} | {61'd0, cmd}, 64'd0);
        chk({tag, "_fields"}, {12'd0, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_data, cmd_idx}, 64'd0);
        chk({tag, "_ready"}, {63'd0, req_ready}, {63'd0, exp_ready});
        chk({tag, "_open"}, {48'd0, bank_open}, {48'd0, open_mask()});
    endtask

    // Present one request after 'gap' idle cycles, follow it to its CAS and
    // check every cycle against the model's predicted command schedule.
    task automatic do_req(input logic [15:0] row, input logic [9:0] col,
                          input logic [1:0] bg, input logic [1:0] ba, input logic t,
                          input logic [15:0] data, input logic [5:0] idx, input int gap,
                          output int a, output int p, output int ac, output int cs);
        int          b;
        logic [15:0] om;
        logic [2:0]  ecmd;
        logic [51:0] ef;
        bit          ev;
        b = {bg, ba};
        repeat (gap) begin
            tick();
            check_quiet("gap", 1'b1);
        end
        tick();
        a = cyc;
        check_quiet("accept", 1'b1);
        req_valid = 1'b1;
        req_row = row; req_col = col; req_bg = bg; req_ba = ba;
        req_t = t; req_data = data; req_idx = idx;

        p  = -1;
        ac = -1;
        if (m_open[b] && m_row[b] == row) begin
            cs = max2(a + 2, last_act[b] + T_RCD);
        end else begin
            if (m_open[b]) begin
                p  = max2(a + 2, last_act[b] + T_RAS);
                ac = p + T_RP;
            end else begin
                ac = max2(a + 2, last_pre[b] + T_RP);
            end
            cs = ac + T_RCD;
        end
        cs = max2(cs, last_cas + T_CCD);
        if (t != m_last_t) cs = max2(cs, last_cas + T_TURN);

        om = open_mask();
        while (cyc < cs) begin
            tick();
            // The sequencer must work from its hold register from here on.
            req_valid = 1'b0;
            req_row = 16'($urandom); req_col = 10'($urandom);
            req_bg = 2'($urandom); req_ba = 2'($urandom); req_t = 1'($urandom);
            req_data = 16'($urandom); req_idx = 6'($urandom);
            ev = 1'b0; ecmd = 3'b000; ef = '0;
            if (cyc == p) begin
                ev = 1'b1; ecmd = 3'b010;
                ef = {bg, ba, 16'd0, 10'd0, 16'd0, 6'd0};
            end else if (cyc == ac) begin
                ev = 1'b1; ecmd = 3'b001;
                ef = {bg, ba, row, 10'd0, 16'd0, 6'd0};
            end else if (cyc == cs) begin
                ev = 1'b1; ecmd = t ? 3'b100 : 3'b011;
                ef = {bg, ba, 16'd0, col, (t ? data : 16'd0), idx};
            end
            chk("cmd_valid", {63'd0, cmd_valid}, {63'd0, ev});
            chk("cmd", {61'd0, cmd}, {61'd0, ecmd});
            chk("cmd_fields", {12'd0, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_data, cmd_idx},
                {12'd0, ef});
            chk("busy_ready", {63'd0, req_ready}, 64'd0);
            chk("bank_open", {48'd0, bank_open}, {48'd0, om});
            if (cyc == p)  om[b] = 1'b0;
            if (cyc == ac) om[b] = 1'b1;
        end

        if (p >= 0) last_pre[b] = p;
        if (ac >= 0) begin
            last_act[b] = ac;
            m_open[b]   = 1'b1;
            m_row[b]    = row;
        end
        last_cas = cs;
        m_last_t = t;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int a, p, ac, cs, x, cs1, cs2, cs3;
        logic [15:0] rows [4];

        cyc = 0; n_checks = 0; n_fail = 0;
        rst_n = 1'b0; req_valid = 1'b0;
        req_row = '0; req_col = '0; req_ba = '0; req_bg = '0;
        req_t = 1'b0; req_data = '0; req_idx = '0;
        model_reset();
        repeat (3) tick();
        check_quiet("reset", 1'b1);
        rst_n = 1'b1;

        // Closed bank 3: ACT at A+2, RD at A+6
        do_req(16'h0012, 10'h005, 2'd0, 2'd3, 1'b0, 16'h1111, 6'd1, 0, a, p, ac, cs);
        chk("t1_act_lat", 64'(ac - a), 64'd2);
        chk("t1_rd_lat", 64'(cs - a), 64'd6);
        chk("t1_no_pre", 64'(p), 64'(-1));
        chk("t1_open", {48'd0, bank_open}, 64'h0008);
        x = ac;

        // Conflict write right after: PRE gated by tRAS
        do_req(16'h0034, 10'h011, 2'd0, 2'd3, 1'b1, 16'hBEEF, 6'd2, 0, a, p, ac, cs);
        chk("t3_pre", 64'(p - x), 64'd8);
        chk("t3_act", 64'(ac - x), 64'd12);
        chk("t3_wr", 64'(cs - x), 64'd16);

        // Row hit: CAS two cycles after accept, no ACT
        do_req(16'h0034, 10'h020, 2'd0, 2'd3, 1'b0, 16'h2222, 6'd3, 0, a, p, ac, cs);
        chk("t2_hit_lat", 64'(cs - a), 64'd2);
        chk("t2_no_act", 64'(ac), 64'(-1));

        // Open bank 5, then read/write and read/read hits across two banks
        do_req(16'h0100, 10'h001, 2'd1, 2'd1, 1'b0, 16'h3333, 6'd4, 0, a, p, ac, cs);
        do_req(16'h0034, 10'h002, 2'd0, 2'd3, 1'b0, 16'h4444, 6'd5, 0, a, p, ac, cs1);
        do_req(16'h0100, 10'h003, 2'd1, 2'd1, 1'b1, 16'h5555, 6'd6, 0, a, p, ac, cs2);
        chk("t4_turn_gap", 64'(cs2 - cs1), 64'd3);
        do_req(16'h0100, 10'h004, 2'd1, 2'd1, 1'b0, 16'h6666, 6'd7, 0, a, p, ac, cs1);
        do_req(16'h0034, 10'h005, 2'd0, 2'd3, 1'b0, 16'h7777, 6'd8, 0, a, p, ac, cs3);
        chk("t4_rr_gap_ge_ccd", {63'd0, 1'((cs3 - cs1) >= T_CCD)}, 64'd1);

        // Reset while waiting tRCD on bank 8
        tick();
        a = cyc;
        check_quiet("t5_accept", 1'b1);
        req_valid = 1'b1; req_row = 16'h0007; req_col = 10'h009;
        req_bg = 2'd2; req_ba = 2'd0; req_t = 1'b0; req_data = '0; req_idx = 6'd9;
        tick();
        req_valid = 1'b0;
        chk("t5_decide_nop", {63'd0, cmd_valid}, 64'd0);
        tick();
        chk("t5_act", {61'd0, cmd}, 64'd1);
        chk("t5_act_row", {48'd0, cmd_row}, 64'h0007);
        tick();
        chk("t5_open_b8", {48'd0, bank_open}, {48'd0, open_mask() | 16'h0100});
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_rst_valid", {63'd0, cmd_valid}, 64'd0);
        chk("t5_rst_cmd", {61'd0, cmd}, 64'd0);
        chk("t5_rst_open", {48'd0, bank_open}, 64'd0);
        chk("t5_rst_ready", {63'd0, req_ready}, 64'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (8) begin
            tick();
            check_quiet("t5_after", 1'b1);
        end

        // Random traffic against the model
        rows[0] = 16'h0000; rows[1] = 16'h0001; rows[2] = 16'h00A5; rows[3] = 16'hFFFF;
        for (int n = 0; n < 500; n++) begin
            do_req(rows[$urandom_range(0, 3)], 10'($urandom), 2'($urandom), 2'($urandom),
                   1'($urandom), 16'($urandom), 6'(n), $urandom_range(0, 3), a, p, ac, cs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bank_cmd_sequencer.md
Name: bank_cmd_sequencer

Overview:
- Sits directly downstream of the 16-queue bank arbiter.
- Accepts one winning request at a time: row, col, bank address, bank group, type, data, index.
- Converts each request into legal DRAM commands (PRE/ACT/RD/WR) under an open-page policy, tracking per-bank open rows and enforcing tRP/tRCD/tRAS/tCCD/turnaround timing.
- Exports per-bank open status back to the arbiter for row-hit prioritisation.

Parameters:
- RA, 16, row address width
- CA, 10, column address width
- DQ, 16, data width
- IDX, 6, request index width
- T_RCD, 4, cycles ACT->RD/WR same bank (>=1)
- T_RP, 4, cycles PRE->ACT same bank (>=1)
- T_RAS, 8, cycles ACT->PRE same bank (>=1)
- T_CCD, 2, cycles CAS->CAS any bank (>=1)
- T_TURN, 3, cycles CAS->CAS when type changes (>=1)
- TW, 4, timer width; must hold max(T_*)-1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  arbiter has a request (arbiter wr_en)
- req_ready  out  1  sequencer accepts request this cycle
- req_row  in  RA  row
- req_col  in  CA  column
- req_ba  in  2  bank address
- req_bg  in  2  bank group
- req_t  in  1  type: 1=write, 0=read
- req_data  in  DQ  write data
- req_idx  in  IDX  request index
- cmd_valid  out  1  command issued this cycle
- cmd  out  3  000 NOP, 001 ACT, 010 PRE, 011 RD, 100 WR
- cmd_ba  out  2  target bank
- cmd_bg  out  2  target bank group
- cmd_row  out  RA  row (ACT only, else 0)
- cmd_col  out  CA  column (RD/WR only, else 0)
- cmd_data  out  DQ  data (WR only, else 0)
- cmd_idx  out  IDX  index (RD/WR only, else 0)
- bank_open  out  16  bit {bg,ba} = bank has open row

Behaviour:
- Clocking and reset:
  - One clock domain; reset is asynchronous and active-low.
  - On reset: FSM=IDLE, req_ready=1, cmd_valid=0, cmd=NOP, all cmd_* fields=0, bank_open=0, all timers=0, last_t=0, hold register cleared.
  - Reset mid-sequence aborts the held request; no further command is issued for it.
- Bank id = {req_bg,req_ba} (0..15).
- Command outputs are Mealy: cmd_valid=1 in the issue cycle only. With cmd_valid=0, cmd=NOP and all fields=0.
- Timers (all decrement by 1 per cycle, saturating at 0; a load wins over the decrement in the same cycle):
  - Per-bank wait_tmr: tRP/tRCD.
  - Per-bank ras_tmr.
  - Global ccd_tmr.
  - Global turn_tmr.
  - A command issued at cycle c loads N-1, so the dependent command is legal from cycle c+N (timer==0).
- FSM:
  - IDLE: req_ready=1. On req_valid, capture all req_* into the hold register -> DECIDE.
  - DECIDE: one cycle, no command.
    - Bank open and row equal (hit) -> CAS.
    - Bank open and row differs (conflict) -> PRE.
    - Bank closed -> ACT.
  - PRE: issue when ras_tmr[b]==0. Clear bank_open[b], load wait_tmr[b]=T_RP-1 -> ACT.
  - ACT: issue when wait_tmr[b]==0. Set bank_open[b], store open_row[b], load wait_tmr[b]=T_RCD-1 and ras_tmr[b]=T_RAS-1 -> CAS.
  - CAS: issue RD or WR per held type when all of the following hold:
    - wait_tmr[b]==0
    - ccd_tmr==0
    - held type==last_t, or turn_tmr==0
  - On CAS issue: load ccd_tmr=T_CCD-1 and turn_tmr=T_TURN-1, update last_t -> IDLE.
- req_ready=0 in every state except IDLE; exactly one request in flight.
- Latency from accept cycle A (defaults, no prior stalls):
  - Hit: CAS at A+2, ready at A+3.
  - Closed bank: ACT at A+2, CAS at A+6.
  - Conflict: PRE at A+2 (if ras_tmr==0), ACT at A+6, CAS at A+10.
- Timers of all 16 banks keep counting while the FSM serves another bank.
- First CAS after reset: last_t=0, so a first write must see turn_tmr==0. It is 0 after reset, so no stall.
- Address/row fields are compared at full width; no wrap arithmetic.

Test Plan:
- Reset, then read row 0x0012 col 0x005 bank 3 (bg=0,ba=3), accepted cycle A:
  - ACT at A+2, cmd_row=0x0012, cmd_bg=0, cmd_ba=3.
  - RD at A+6, cmd_col=0x005.
  - bank_open=0x0008.
- Second read, same bank and row, accepted the cycle req_ready returns: RD two cycles after accept, no ACT.
- Write to bank 3 row 0x0034 right after the ACT at cycle X:
  - PRE waits for ras_tmr, issued at X+8.
  - ACT row 0x0034 at X+12.
  - WR at X+16 with cmd_data/cmd_idx equal to request.
- Back-to-back hits on two open banks, read then write:
  - Second CAS no earlier than T_TURN=3 cycles after the first.
  - Read after read to different banks spaced by T_CCD=2.
- Assert rst_n low during ACT->CAS wait:
  - Outputs go to reset values immediately, bank_open=0, no RD emitted.
  - After release, req_ready=1 on the next cycle.
- Random 500 requests (with a reference model of open rows and timers): every command meets tRP/tRCD/tRAS/tCCD/turnaround; RD/WR order and idx match acceptance order.
